// File: rtl/rs232_tx.sv
// rs232_tx -- buffered RS-232 style serial transmitter.
//
// Bytes written on wr_en are queued in a 4-entry FIFO. The transmitter sends
// each one as a frame: a start bit (0), eight data bits LSB first, an optional
// parity bit, and a stop bit (1). Each bit lasts CLK_DIV clock cycles. When the
// FIFO still holds a byte at the end of a stop bit, the next frame starts on
// the following cycle with no idle gap between frames.
//
// Parameters:
//   CLK_DIV    clk cycles per serial bit (2..65535)
//   PARITY_EN  1 = insert a parity bit after data bit 7
//   PARITY_ODD 0 = even parity, 1 = odd parity
//
// Ports:
//   clk       system clock, posedge
//   rst_n     asynchronous active-low reset
//   wr_en     write request for wr_data
//   wr_data   byte to transmit
//   full      FIFO holds 4 entries
//   overflow  one-cycle pulse after a rejected write
//   busy      a frame is on the line or the FIFO is non-empty
//   tx        serial line, idle high, registered
module rs232_tx #(
    parameter int unsigned CLK_DIV    = 16,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       tx
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

    // FIFO
    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       push, pop;

    // Transmitter
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
    // Records that the FIFO was already non-empty one cycle earlier; starting
    // from IDLE waits on it, so a write into an idle transmitter reaches the
    // line two edges after it is accepted.
    logic        nonempty_q, nonempty_d;

    assign full     = (count_q == 3'd4);
    assign busy     = !((state_q == S_IDLE) && (count_q == 3'd0));
    assign overflow = ovf_q;
    assign tx       = tx_q;

    // A write into a full FIFO is rejected even if a pop happens the same cycle.
    assign push = wr_en && !full;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        ovf_d      = wr_en && full;
        nonempty_d = (count_q != 3'd0);

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (nonempty_q && (count_q != 3'd0)) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    par_d   = (^mem_q[rd_ptr_q]) ^ PARITY_ODD;
                    state_d = S_START;
                    cnt_d   = BIT_RELOAD;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    state_d   = S_DATA;
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = 3'd0;
                    tx_d      = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Bit 0 of the shifted register is always the bit on the line.
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PARITY: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_STOP;
                    cnt_d   = BIT_RELOAD;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (count_q != 3'd0) begin
                        // Back-to-back frame: go straight to START.
                        pop     = 1'b1;
                        shreg_d = mem_q[rd_ptr_q];
                        par_d   = (^mem_q[rd_ptr_q]) ^ PARITY_ODD;
                        state_d = S_START;
                        cnt_d   = BIT_RELOAD;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 16'd0;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
                tx_d    = 1'b1;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'd0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
            nonempty_q <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            ovf_q      <= ovf_d;
            nonempty_q <= nonempty_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: three instances (no parity, even parity, odd parity),
// CLK_DIV=4, all fed the same writes. A queue-based frame model per instance
// predicts tx/busy/full/overflow each cycle; literal checks pin key timings.
module tb_rs232_tx;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [2:0] full, ovf, busy, tx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs232_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_np (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full[0]), .overflow(ovf[0]), .busy(busy[0]), .tx(tx[0]));
    rs232_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_pe (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full[1]), .overflow(ovf[1]), .busy(busy[1]), .tx(tx[1]));
    rs232_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_po (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full[2]), .overflow(ovf[2]), .busy(busy[2]), .tx(tx[2]));

    // Model: a byte queue plus a queue of line levels still to be driven.
    for (genvar g = 0; g < 3; g++) begin : m
        localparam bit PE = (g != 0);
        localparam bit PO = (g == 2);
        logic       line[$];
        logic [7:0] fifo[$];
        int         prev_pre = 0;
        bit         in_frame = 1'b0;
        logic       etx = 1'b1, ebusy = 1'b0, efull = 1'b0, eovf = 1'b0;

        always @(posedge clk or negedge rst_n) begin : mdl
            int         pre;
            bit         start;
            logic [7:0] b;
            if (!rst_n) begin
                line.delete();
                fifo.delete();
                prev_pre = 0;
                in_frame = 1'b0;
                etx = 1'b1; ebusy = 1'b0; efull = 1'b0; eovf = 1'b0;
            end else begin
                pre   = fifo.size();
                start = 1'b0;
                if (line.size() > 0) etx = line.pop_front();
                else if (in_frame && pre > 0) start = 1'b1;
                else if (in_frame) begin in_frame = 1'b0; etx = 1'b1; end
                // From idle, a byte must have been queued for two edges.
                else if (pre > 0 && prev_pre > 0) start = 1'b1;
                if (start) begin
                    b = fifo.pop_front();
                    for (int r = 0; r < DIV; r++) line.push_back(1'b0);
                    for (int i = 0; i < 8; i++)
                        for (int r = 0; r < DIV; r++) line.push_back(b[i]);
                    if (PE)
                        for (int r = 0; r < DIV; r++) line.push_back((^b) ^ PO);
                    for (int r = 0; r < DIV; r++) line.push_back(1'b1);
                    in_frame = 1'b1;
                    etx = line.pop_front();
                end
                eovf = wr_en && (pre == 4);
                if (wr_en && pre < 4) fifo.push_back(wr_data);
                efull    = (fifo.size() == 4);
                ebusy    = in_frame || (fifo.size() != 0);
                prev_pre = pre;
            end
        end
    end

    task automatic chk(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%b exp=%b @%0t", nm, a, e, $time);
        end
    endtask

    task automatic chkv(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d @%0t", nm, a, e, $time);
        end
    endtask

    task automatic cmp_dut(input int g, input logic et, input logic eb,
                           input logic ef, input logic eo);
        chk($sformatf("tx%0d", g), tx[g], et);
        chk($sformatf("busy%0d", g), busy[g], eb);
        chk($sformatf("full%0d", g), full[g], ef);
        chk($sformatf("ovf%0d", g), ovf[g], eo);
    endtask

    // Advance one cycle; compare every instance against the model.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            cmp_dut(0, m[0].etx, m[0].ebusy, m[0].efull, m[0].eovf);
            cmp_dut(1, m[1].etx, m[1].ebusy, m[1].efull, m[1].eovf);
            cmp_dut(2, m[2].etx, m[2].ebusy, m[2].efull, m[2].eovf);
        end
    endtask

    task automatic reset_vals(input string nm);
        for (int g = 0; g < 3; g++) begin
            chk({nm, "_tx"}, tx[g], 1'b1);
            chk({nm, "_busy"}, busy[g], 1'b0);
            chk({nm, "_full"}, full[g], 1'b0);
            chk({nm, "_ovf"}, ovf[g], 1'b0);
        end
    endtask

    initial begin
        logic [9:0] f55;
        int novf;
        f55 = 10'b10_1010_1010;  // index = bit slot: start, data LSB first, stop

        #2 rst_n = 1'b0;
        tick(); tick();
        reset_vals("rst");
        rst_n = 1'b1;
        tick(); tick();

        // Single 0x55 frame: latency and waveform.
        wr_en = 1'b1; wr_data = 8'h55;
        tick(); wr_en = 1'b0;                        // edge N
        chk("lat_n0", tx[0], 1'b1);
        tick();                                      // N+1
        chk("lat_n1", tx[0], 1'b1);
        chk("lat_busy", busy[0], 1'b1);
        tick();                                      // N+2
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < DIV; j++) begin
                if (i != 0 || j != 0) tick();
                chk($sformatf("f55_b%0d", i), tx[0], f55[i]);
            end
        tick();                                      // N+42
        chk("f55_busy_end", busy[0], 1'b0);
        repeat (10) tick();

        // Back-to-back frames 0xA3, 0x0F.
        wr_en = 1'b1; wr_data = 8'hA3; tick();       // N
        wr_data = 8'h0F; tick();                     // N+1
        wr_en = 1'b0;
        repeat (40) tick();                          // N+41
        chk("b2b_stop", tx[0], 1'b1);
        tick();                                      // N+42
        chk("b2b_start", tx[0], 1'b0);
        chk("b2b_busy", busy[0], 1'b1);
        repeat (100) tick();

        // Eight writes in a row, then a write into full at the stop-bit pop.
        novf = 0;
        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(k);
            tick();
            novf += int'(ovf[0]);
        end
        wr_en = 1'b0;
        chkv("ovf_pulses", novf, 3);
        chk("full_after", full[0], 1'b1);
        repeat (34) tick();                          // N+41
        wr_en = 1'b1; wr_data = 8'hEE;
        tick(); wr_en = 1'b0;                        // N+42: pop + rejected write
        chk("popfull_ovf", ovf[0], 1'b1);
        chk("popfull_full", full[0], 1'b0);
        tick();
        chk("popfull_ovf_end", ovf[0], 1'b0);
        repeat (200) tick();

        // Parity on 0x07.
        wr_en = 1'b1; wr_data = 8'h07;
        tick(); wr_en = 1'b0;                        // k=0 -> edge N
        for (int k = 1; k <= 46; k++) begin
            tick();
            if (k == 39) begin
                chk("par_even", tx[1], 1'b1);
                chk("par_odd", tx[2], 1'b0);
            end
            if (k == 42) chk("par_np_done", busy[0], 1'b0);
            if (k == 45) chk("par_len_busy", busy[1], 1'b1);
            if (k == 46) chk("par_len_done", busy[1], 1'b0);
        end
        repeat (10) tick();

        // Reset during data bit 3 with two bytes queued.
        wr_en = 1'b1; wr_data = 8'h81; tick();
        wr_data = 8'h42; tick();
        wr_data = 8'h24; tick();
        wr_en = 1'b0;                                // after N+2
        repeat (16) tick();                          // after N+18
        chk("pre_rst_bit3", tx[0], 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 reset_vals("midrst");
        tick(); tick();
        rst_n = 1'b1;
        repeat (60) tick();
        chk("post_rst_tx", tx[0], 1'b1);
        chk("post_rst_busy", busy[0], 1'b0);

        // First write after reset.
        wr_en = 1'b1; wr_data = 8'h3C;
        tick(); wr_en = 1'b0;
        chk("rlat_n0", tx[0], 1'b1);
        tick();
        chk("rlat_n1", tx[0], 1'b1);
        tick();
        chk("rlat_n2", tx[0], 1'b0);
        repeat (60) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
